// File: rtl/moore_seq_det_n.sv
// rtl/moore_seq_det_n.sv - Moore sequence detector for a runtime N-bit pattern with saturating match counter
// Optional macro SEQ_DET_LOCK_EN: MATCH becomes absorbing until clear or reset.
module moore_seq_det_n #(
  parameter int N     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic [N-1:0]     pattern,
  input  logic             overlap,
  input  logic             clear,
  output logic             y,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int KW = $clog2(N);

  typedef enum logic {
    S_TRACK,
    S_MATCH
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [KW-1:0]    k;
  logic [KW-1:0]    k_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [N-1:0]     pv;
  logic [N-1:0]     hist;
  logic [N-1:0]     pj;
  logic [N-1:0]     mask;
  logic             lock_hold;
  int               m;
  int               len;
  int               best;

`ifdef SEQ_DET_LOCK_EN
  assign lock_hold = (state == S_MATCH);
`else
  assign lock_hold = 1'b0;
`endif

  assign y = (state == S_MATCH);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_TRACK;
      k         <= '0;
      match_cnt <= '0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      match_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_nxt   = match_cnt;
    m         = 0;
    len       = 0;
    best      = 0;
    pv        = '0;
    hist      = '0;
    pj        = '0;
    mask      = '0;

    // The tracked history is implied by the state: the first m pattern bits, then x.
    if (state == S_MATCH) begin
      if (overlap) begin
        m   = N;
        len = N + 1;
      end else begin
        m   = 0;
        len = 1;
      end
    end else begin
      m   = int'(k);
      len = m + 1;
    end

    pv   = pattern >> (N - m);
    hist = N'({pv, x});

    // Failure function: longest history suffix equal to a pattern prefix.
    for (int j = 1; j <= N; j++) begin
      pj   = pattern >> (N - j);
      mask = {N{1'b1}} >> (N - j);
      if ((j <= len) && (((hist ^ pj) & mask) == '0)) begin
        best = j;
      end
    end

    if (clear) begin
      state_nxt = S_TRACK;
      k_nxt     = '0;
      cnt_nxt   = '0;
    end else if (x_valid && !lock_hold) begin
      if (best == N) begin
        state_nxt = S_MATCH;
        k_nxt     = '0;
        if (match_cnt != {CNT_W{1'b1}}) begin
          cnt_nxt = match_cnt + 1'b1;
        end
      end else begin
        state_nxt = S_TRACK;
        k_nxt     = KW'(best);
      end
    end
  end

endmodule
